vram_term_writer: RTL

Serial-terminal text engine that drives the write port of the 64x32 character VRAM. It consumes received bytes through a valid/ready handshake and maintains a cursor. Printable characters are written at the cursor; CR, LF, BS and FF are interpreted. At the bottom row it scrolls by advancing a hardware scroll offset and blanking the recycled row, so the text renderer on the VRAM read port never has to move memory.

---
 rtl/vram_term_writer_if.sv | 13 +
 rtl/vram_term_writer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vram_term_writer_if.sv
// Receive-side byte handshake between a byte source and the terminal writer.
//   rx_data  : received byte
//   rx_valid : rx_data is valid; held by the source until accepted
//   rx_ready : sink can accept a byte; transfer on the edge where both are high
// master modport = byte source, slave modport = vram_term_writer.
interface vram_term_writer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/vram_term_writer.sv
// Serial-terminal text engine driving the write port of a COLS x ROWS
// character VRAM. Printable bytes are written at the cursor; CR, LF, BS and
// FF are interpreted. Scrolling advances a hardware scroll offset and blanks
// the recycled physical row, so the renderer never has to move memory.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   rx         : byte handshake (slave side: rx_data, rx_valid in; rx_ready out)
//   vram_ad    : VRAM write address {phys_row, col}
//   vram_din   : VRAM write data
//   vram_we    : VRAM write strobe (CE and WRE)
//   cur_col    : cursor column
//   cur_row    : cursor logical row (0 = screen top)
//   scroll_row : physical VRAM row shown at the screen top
//   busy       : high while a row or screen clear is running
module vram_term_writer #(
  parameter int          COLS  = 64,
  parameter int          ROWS  = 32,
  parameter logic [7:0]  BLANK = 8'h20,
  localparam int         CW    = $clog2(COLS),
  localparam int         RW    = $clog2(ROWS),
  localparam int         AW    = CW + RW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vram_term_writer_if.slave     rx,
  output logic [AW-1:0]         vram_ad,
  output logic [7:0]            vram_din,
  output logic                  vram_we,
  output logic [CW-1:0]         cur_col,
  output logic [RW-1:0]         cur_row,
  output logic [RW-1:0]         scroll_row,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PUT     = 2'd1;
  localparam logic [1:0] ST_CLR_ROW = 2'd2;
  localparam logic [1:0] ST_CLR_SCR = 2'd3;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  logic [1:0]    state;
  logic [RW-1:0] phys_row;
  logic          rx_fire;
  logic          is_printable;

  // Physical row wraps naturally in RW bits.
  assign phys_row     = scroll_row + cur_row;
  assign rx_fire      = rx.rx_valid & rx.rx_ready;
  assign is_printable = ((rx.rx_data >= 8'h20) && (rx.rx_data <= 8'h7E)) ||
                        (rx.rx_data >= 8'hA0);

  // During clears the write address register doubles as the clear counter:
  // its column field counts a row clear, the whole address counts a screen
  // clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rx.rx_ready <= 1'b1;
      vram_ad     <= '0;
      vram_din    <= '0;
      vram_we     <= 1'b0;
      cur_col     <= '0;
      cur_row     <= '0;
      scroll_row  <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_fire) begin
            if (is_printable) begin
              vram_ad     <= {phys_row, cur_col};
              vram_din    <= rx.rx_data;
              vram_we     <= 1'b1;
              rx.rx_ready <= 1'b0;
              state       <= ST_PUT;
            end else begin
              case (rx.rx_data)
                CH_CR: cur_col <= '0;
                CH_LF: begin
                  if (cur_row != '1) begin
                    cur_row <= cur_row + RW'(1);
                  end else begin
                    // Recycle the row that was at the top of the screen.
                    scroll_row  <= scroll_row + RW'(1);
                    vram_ad     <= {scroll_row, {CW{1'b0}}};
                    vram_din    <= BLANK;
                    vram_we     <= 1'b1;
                    rx.rx_ready <= 1'b0;
                    busy        <= 1'b1;
                    state       <= ST_CLR_ROW;
                  end
                end
                CH_BS: begin
                  if (cur_col != '0) cur_col <= cur_col - CW'(1);
                end
                CH_FF: begin
                  scroll_row  <= '0;
                  cur_row     <= '0;
                  cur_col     <= '0;
                  vram_ad     <= '0;
                  vram_din    <= BLANK;
                  vram_we     <= 1'b1;
                  rx.rx_ready <= 1'b0;
                  busy        <= 1'b1;
                  state       <= ST_CLR_SCR;
                end
                default: ;  // ignored byte, consumed
              endcase
            end
          end
        end

        ST_PUT: begin
          vram_we <= 1'b0;
          if (cur_col == '1) begin
            cur_col <= '0;
            if (cur_row != '1) begin
              cur_row     <= cur_row + RW'(1);
              rx.rx_ready <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              scroll_row  <= scroll_row + RW'(1);
              vram_ad     <= {scroll_row, {CW{1'b0}}};
              vram_din    <= BLANK;
              vram_we     <= 1'b1;
              busy        <= 1'b1;
              state       <= ST_CLR_ROW;
            end
          end else begin
            cur_col     <= cur_col + CW'(1);
            rx.rx_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        ST_CLR_ROW: begin
          if (vram_ad[CW-1:0] == '1) begin
            vram_we     <= 1'b0;
            busy        <= 1'b0;
            rx.rx_ready <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            vram_ad <= vram_ad + AW'(1);
          end
        end

        ST_CLR_SCR: begin
          if (vram_ad == '1) begin
            vram_we     <= 1'b0;
            busy        <= 1'b0;
            rx.rx_ready <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            vram_ad <= vram_ad + AW'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
